// File: rtl/lfsr_draw_pkg.sv
// lfsr_draw_pkg: shared definitions for the LFSR draw arbiter.
//   state_t      - arbiter FSM encoding (IDLE / STEP / DONE)
//   TAP_MASK     - feedback taps {8,7,6,3,0} of x^8+x^7+x^6+x^3+1
//   DEFAULT_SEED - reset / default seed (non-zero)
//   CNT_W        - width of the per-draw step counter
//   lfsr_next()  - one right-shift step of the 9-bit Fibonacci LFSR
package lfsr_draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          LFSR_W       = 9;
  localparam logic [8:0]  TAP_MASK     = 9'b1_1100_1001;
  localparam logic [8:0]  DEFAULT_SEED = 9'h001;
  localparam int          CNT_W        = 8;

  // Feedback is the parity of the tapped bits; it enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {^(v & TAP_MASK), v[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_draw_arbiter_core.sv
// lfsr_core: the (N+1)-bit LFSR register.
//   clk, reset (async, active low -> q = SEED)
//   advance  : shift one step this cycle
//   load     : load load_val (zero is remapped to 1 to avoid lock-up);
//              load wins over advance
//   q        : current LFSR state
module lfsr_core
  import lfsr_draw_pkg::*;
#(
  parameter int         N    = 8,
  parameter logic [N:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       load,
  input  logic [N:0] load_val,
  output logic [N:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= SEED;
    else if (load)
      q <= (load_val == '0) ? (N+1)'(1) : load_val;
    else if (advance)
      q <= lfsr_next(q);
  end

endmodule

// File: rtl/lfsr_draw_arbiter.sv
// lfsr_draw_arbiter: round-robin arbiter sharing one LFSR among NREQ
// requesters. Each granted draw advances the LFSR STEPS times and delivers
// the resulting word.
//   clk, reset    : clock, async active-low reset
//   req[NREQ]     : level requests, held until the matching gnt pulse
//   seed_we       : seed-load strobe (honoured only in IDLE)
//   seed_val[N+1] : seed value (0 maps to 1)
//   gnt[NREQ]     : one-hot single-cycle grant, coincident with rnd_valid
//   rnd[N+1]      : delivered word, held until the next delivery
//   rnd_valid     : pulse when rnd is new
//   busy          : high in STEP and DONE
module lfsr_draw_arbiter
  import lfsr_draw_pkg::*;
#(
  parameter int         N     = 8,
  parameter int         NREQ  = 4,
  parameter int         STEPS = 8,
  parameter logic [N:0] SEED  = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            seed_we,
  input  logic [N:0]      seed_val,
  output logic [NREQ-1:0] gnt,
  output logic [N:0]      rnd,
  output logic            rnd_valid,
  output logic            busy
);

  localparam int               PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   pick;
  logic               found;
  logic [CNT_W-1:0]   step_cnt;
  logic [N:0]         lfsr_q;
  logic               lfsr_adv;
  logic               lfsr_load;

  // Only STEP moves the generator; seeds are accepted only while idle.
  assign lfsr_adv  = (state == ST_STEP);
  assign lfsr_load = (state == ST_IDLE) && seed_we;

  lfsr_core #(.N(N), .SEED(SEED)) u_core (
    .clk      (clk),
    .reset    (reset),
    .advance  (lfsr_adv),
    .load     (lfsr_load),
    .load_val (seed_val),
    .q        (lfsr_q)
  );

  // Round-robin search: first set request strictly after the last winner.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(rr_ptr) + i) % NREQ]) begin
        pick  = PTR_W'((int'(rr_ptr) + i) % NREQ);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= PTR_W'(NREQ - 1);
      sel       <= '0;
      step_cnt  <= '0;
      gnt       <= '0;
      rnd       <= '0;
      rnd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!seed_we && found) begin
            sel      <= pick;
            step_cnt <= STEPS_C;
            busy     <= 1'b1;
            state    <= ST_STEP;
          end
        end
        ST_STEP: begin
          step_cnt <= step_cnt - 1'b1;
          if (step_cnt == CNT_W'(1)) begin
            // Capture the post-advance value so rnd is valid on DONE entry.
            rnd       <= lfsr_next(lfsr_q);
            gnt       <= NREQ'(1) << sel;
            rnd_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt       <= '0;
          rnd_valid <= 1'b0;
          busy      <= 1'b0;
          rr_ptr    <= sel;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lfsr_draw_arbiter.md
Name: lfsr_draw_arbiter

Overview:
- Shares one (N+1)-bit Fibonacci LFSR between NREQ requesters; each granted request receives one fresh pseudo-random word.
- The polynomial is x^8+x^7+x^6+x^3+1. Feedback is r[8]^r[7]^r[6]^r[3]^r[0], which enters at the MSB; the register shifts right each step.
- Round-robin arbitration. Per draw, the LFSR advances STEPS times to decorrelate successive outputs.
- A seed-load port (re)initialises the generator.
- Sits between the random-consuming blocks and the LFSR datapath, and is the only owner of the LFSR.

Parameters:
- N, 8: LFSR index MSB. The register is N+1 = 9 bits, and the tap set is fixed for N=8.
- NREQ, 4: number of requesters, 2..8.
- STEPS, 8: LFSR advances per draw, 1..255.
- SEED, 9'h001: reset and default seed value. Must be non-zero.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- req, input, NREQ: per-requester draw request (level). The requester holds it until its gnt pulse.
- seed_we, input, 1: seed-load strobe.
- seed_val, input, N+1: seed value.
- gnt, output, NREQ: one-hot, single-cycle grant, coincident with rnd_valid.
- rnd, output, N+1: delivered random word. Registered; holds until the next delivery.
- rnd_valid, output, 1: single-cycle pulse when rnd is new.
- busy, output, 1: high in STEP and DONE.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, lfsr=SEED, rr_ptr=NREQ-1, so requester 0 has first priority.
  - gnt=0, rnd=0, rnd_valid=0, busy=0, step_cnt=0.
  - Reset mid-draw aborts the draw; no gnt is issued for it.
- FSM states: IDLE, STEP, DONE.
- IDLE:
  - If seed_we: lfsr <= (seed_val==0) ? 1 : seed_val (zero-lockup guard). Stay in IDLE. seed_we has priority over req in the same cycle, and req is served on a following cycle.
  - Else if |req: choose the first set req bit, searching from rr_ptr+1 upward modulo NREQ. Latch its index in sel, set step_cnt <= STEPS, and go to STEP.
  - Else: stay in IDLE; the LFSR holds.
- STEP:
  - Each cycle: lfsr <= {fb, lfsr[N:1]} and step_cnt--.
  - After the STEPS-th advance (step_cnt==1 at the edge), go to DONE.
  - seed_we is ignored (dropped) while busy.
  - req changes are ignored; the selection is fixed at entry.
- DONE (one cycle):
  - rnd_valid=1, gnt[sel]=1, rnd=lfsr. rnd is registered on entry, so it equals the LFSR value after STEPS advances.
  - rr_ptr <= sel, then go to IDLE.
  - The grant is delivered even if req[sel] dropped during STEP.
- Latency: req sampled in IDLE at edge t gives gnt/rnd_valid high in cycle t+STEPS+1. The minimum spacing between draws is STEPS+2 cycles.
- The LFSR advances only in STEP. It never advances in IDLE or DONE.
- gnt is always one-hot or zero. rnd_valid == |gnt.
- Arithmetic:
  - step_cnt is 8 bits and unsigned.
  - rr_ptr wraps from NREQ-1 to 0.

Decomposition:
- Package lfsr_draw_pkg holds:
  - the state encoding (IDLE/STEP/DONE);
  - the tap positions {8,7,6,3,0};
  - the default SEED;
  - the step counter width.
- One sub-module, lfsr_core: an (N+1)-bit register with the async active-low reset to SEED, an enable (advance), and load/load_val (zero mapped to 1). It exposes q.
- The arbiter FSM and round-robin pointer stay in lfsr_draw_arbiter.

Test Plan:
- Reset release, then req=4'b0001 held with STEPS=8 and SEED=1 → gnt=0001 and rnd_valid in cycle t+9, with rnd=9'h0E6. The intermediate LFSR trace is 100, 180, 0C0, 060, 130, 198, 1CC, 0E6.
- req=4'b1111 held continuously → gnt sequence 0001, 0010, 0100, 1000, 0001, one grant every 10 cycles. rnd values match a C/SV reference model of the polynomial.
- In IDLE, seed_we=1 with seed_val=0 and req=0001 in the same cycle → lfsr loads 9'h001 and no draw starts that cycle. The draw starts the next cycle, and the delivered rnd is 9'h0E6.
- seed_we=1 with seed_val=9'h1FF during STEP → ignored. rnd equals the value from continuing the unseeded sequence.
- reset pulsed low during STEP (step_cnt=4) → busy, gnt, and rnd_valid go to 0 immediately and lfsr=001. After release with req=0010, the delivered rnd is 9'h0E6 to gnt=0010.
- req[2] pulsed for one cycle in IDLE, then dropped → gnt=0100 still delivered with rnd_valid, and rr_ptr=2, so the next req=1111 is served requester 3 first.
